// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor with borrow flop and start/ready, valid/ack handshakes
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             valid,
    input  logic             ack
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic             valid_q, valid_d;

    logic             x, y, c, d_bit, brw_nxt;
    logic [WIDTH-1:0] res_shift;

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        valid_d = valid_q;

        // Single full-subtractor cell on the current LSBs.
        x       = a_sr_q[0];
        y       = b_sr_q[0];
        c       = brw_q;
        d_bit   = x ^ y ^ c;
        brw_nxt = (~x & y) | (~(x ^ y) & c);

        // Written as shift-then-set so WIDTH=1 needs no special case.
        res_shift            = res_q >> 1;
        res_shift[WIDTH-1]   = d_bit;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a_in;
                    b_sr_d  = b_in;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                brw_d  = brw_nxt;
                res_d  = res_shift;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    diff_d  = res_shift;
                    bout_d  = brw_nxt;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            valid_q <= valid_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign diff  = diff_q;
    assign bout  = bout_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and model-checked bench for serial_subtractor
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       ready;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       valid;
    logic       ack;

    int checks;
    int failures;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .ready (ready),
        .a_in  (a_in),
        .b_in  (b_in),
        .bin   (bin),
        .diff  (diff),
        .bout  (bout),
        .valid (valid),
        .ack   (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bi);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_start", 32'(ready), 32'd1);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        bin   = bi;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = 8'hA5;
        b_in  = 8'h5A;
        bin   = 1'b1;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic bi, input logic [8:0] exp);
        int lat;
        start_op(a, b, bi);
        wait_valid(lat);
        check({tag, "_latency"}, 32'(lat), 32'd8);
        check({tag, "_result"}, 32'({bout, diff}), 32'(exp));
        do_ack();
        check({tag, "_valid_after_ack"}, 32'(valid), 32'd0);
        check({tag, "_ready_after_ack"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int         lat;
        bit         stable;
        logic [7:0] ra, rb;
        logic       rbi;
        logic [8:0] rexp;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        ack      = 1'b0;
        a_in     = '0;
        b_in     = '0;
        bin      = 1'b0;

        #2;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // {bout, diff} hand-computed
        run_vec("t1_5m3", 8'h05, 8'h03, 1'b0, 9'h002);
        run_vec("t2_0m1", 8'h00, 8'h01, 1'b0, 9'h1FF);
        run_vec("t3_ffmffm1", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
        run_vec("t3_80m7fm1", 8'h80, 8'h7F, 1'b1, 9'h000);
        run_vec("t3_c3m41", 8'hC3, 8'h41, 1'b0, 9'h082);

        // start during RUN must be ignored
        start_op(8'h05, 8'h03, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        a_in  = 8'h10;
        b_in  = 8'h01;
        bin   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_valid(lat);
        check("t4_latency", 32'(lat), 32'd4);
        check("t4_result", 32'({bout, diff}), 32'h002);
        stable = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (valid !== 1'b1 || diff !== 8'h02 || bout !== 1'b0 || ready !== 1'b0) stable = 1'b0;
        end
        check("t4_hold_stable", 32'(stable), 32'd1);
        @(negedge clk);
        ack   = 1'b1;
        start = 1'b1;
        a_in  = 8'hFF;
        b_in  = 8'h00;
        @(posedge clk);
        #1;
        ack   = 1'b0;
        start = 1'b0;
        check("t4_valid_after_ack", 32'(valid), 32'd0);
        check("t4_ready_after_ack", 32'(ready), 32'd1);
        check("t4_diff_held", 32'(diff), 32'h02);
        @(posedge clk);
        #1;
        check("t4_start_dropped", 32'(ready), 32'd1);

        // reset at bit 4 aborts the run
        start_op(8'h40, 8'h01, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_ready", 32'(ready), 32'd1);
        check("t5_rst_valid", 32'(valid), 32'd0);
        check("t5_rst_diff", 32'(diff), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("t5_after_rst", 8'h40, 8'h01, 1'b0, 9'h03F);

        // reference model: {bout, diff} = a - b - bin
        for (int i = 0; i < 200; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbi  = 1'($urandom);
            rexp = {1'b0, ra} - {1'b0, rb} - {8'h00, rbi};
            start_op(ra, rb, rbi);
            wait_valid(lat);
            check("t6_rand_latency", 32'(lat), 32'd8);
            check("t6_rand_result", 32'({bout, diff}), 32'(rexp));
            do_ack();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
